// File: rtl/xera4_video_scanout.sv
// XERA4 display refresh: 640x480 VGA timing, 4x4-replicated fetch of a 160x120
// RGB332 framebuffer from the read port of video RAM, with a fixed 3-clock pipeline.
module xera4_video_scanout #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter int   SCALE_LOG2 = 2,
  parameter int   ROW_BYTES  = H_ACTIVE >> SCALE_LOG2,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] Video_Add,
  input  logic [7:0]  Video_In,
  input  logic [14:0] base_add,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0]   ROW_STEP = 15'(ROW_BYTES);

  logic [HW-1:0] h_r, h_nxt_s;
  logic [VW-1:0] v_r, v_nxt_s;
  logic          h_end_s, v_end_s, row_end_s;
  logic          active_s, hs_raw_s, vs_raw_s;
  logic [14:0]   line_base_r, fetch_add_s;
  logic [1:0]    act_d_r, hs_d_r, vs_d_r;

  // Next raster position; v steps only when h wraps.
  always_comb begin
    h_end_s   = (h_r == H_LAST);
    v_end_s   = (v_r == V_LAST);
    h_nxt_s   = h_r + HW'(1);
    v_nxt_s   = v_r;
    if (h_end_s) begin
      h_nxt_s = {HW{1'b0}};
      if (v_end_s) begin
        v_nxt_s = {VW{1'b0}};
      end else begin
        v_nxt_s = v_r + VW'(1);
      end
    end else begin
      v_nxt_s = v_r;
    end
  end

  // Active-region, sync windows and fetch address for the current position.
  always_comb begin
    active_s    = (h_r < H_ACT) && (v_r < V_ACT);
    row_end_s   = h_end_s && (v_r < V_ACT) && (v_r[1:0] == 2'b11);
    fetch_add_s = line_base_r + 15'(h_r >> SCALE_LOG2);
    if ((h_r >= HS_START) && (h_r < HS_END)) begin
      hs_raw_s = SYNC_POL;
    end else begin
      hs_raw_s = ~SYNC_POL;
    end
    if ((v_r >= VS_START) && (v_r < VS_END)) begin
      vs_raw_s = SYNC_POL;
    end else begin
      vs_raw_s = ~SYNC_POL;
    end
  end

  // Raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r <= {HW{1'b0}};
      v_r <= {VW{1'b0}};
    end else begin
      h_r <= h_nxt_s;
      v_r <= v_nxt_s;
    end
  end

  // Row start address: base_add is taken directly at the frame wrap (this is the
  // frame's latched base), then advances one framebuffer row every fourth line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_base_r <= 15'h0000;
    end else if (h_end_s && v_end_s) begin
      line_base_r <= base_add;
    end else if (row_end_s) begin
      line_base_r <= line_base_r + ROW_STEP;
    end else begin
      line_base_r <= line_base_r;
    end
  end

  // RAM read address; holds through blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Video_Add <= 15'h0000;
    end else if (active_s) begin
      Video_Add <= fetch_add_s;
    end else begin
      Video_Add <= Video_Add;
    end
  end

  // Two-stage delay plus output register keeps de/syncs aligned with colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_d_r <= 2'b00;
      hs_d_r  <= {2{~SYNC_POL}};
      vs_d_r  <= {2{~SYNC_POL}};
      de      <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else begin
      act_d_r <= {act_d_r[0], active_s};
      hs_d_r  <= {hs_d_r[0], hs_raw_s};
      vs_d_r  <= {vs_d_r[0], vs_raw_s};
      de      <= act_d_r[1];
      hsync   <= hs_d_r[1];
      vsync   <= vs_d_r[1];
    end
  end

  // Colour register; enable gates immediately with no line alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {red, green, blue} <= 8'h00;
    end else if (act_d_r[1] && enable) begin
      {red, green, blue} <= Video_In;
    end else begin
      {red, green, blue} <= 8'h00;
    end
  end

  // Frame pacing flags track the counters, not the pixel pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vblank      <= (v_nxt_s >= V_ACT);
      frame_start <= (h_nxt_s == {HW{1'b0}}) && (v_nxt_s == V_ACT);
    end
  end

endmodule
